// File: rtl/ifm_pack_pkg.sv
// Shared constants, types and helpers for the IFM write-side chunk packer.
// Holds the default vector/chunk geometry, the widths derived from it, the
// lane/vector types and the packer FSM state encoding.
package ifm_pack_pkg;

  localparam int unsigned VEC_SIZE   = 16;
  localparam int unsigned CHUNK_SIZE = 128;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned SPM_DEPTH  = CHUNK_SIZE / VEC_SIZE;

  localparam int unsigned ADDR_W = $clog2(CHUNK_SIZE) + 1;
  localparam int unsigned SPM_AW = $clog2(SPM_DEPTH);
  localparam int unsigned LANE_W = $clog2(VEC_SIZE);
  localparam int unsigned CNT_W  = $clog2(VEC_SIZE) + 1;

  typedef logic [DATA_W-1:0]   lane_t;
  typedef lane_t [VEC_SIZE-1:0] vec_t;   // lane i occupies bits [i*DATA_W +: DATA_W]
  typedef logic [VEC_SIZE-1:0] mask_t;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    FIN
  } state_t;

  // Sparsemap word of a dense vector: bit i set iff lane i is nonzero.
  function automatic mask_t nz_mask(input vec_t v);
    mask_t m;
    for (int i = 0; i < int'(VEC_SIZE); i++) begin
      m[i] = |v[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/ifm_chunk_packer_if.sv
// Dense-vector stream from the IFM loader into the chunk packer.
//   in_valid_i / in_ready_o   : handshake
//   in_data_i                 : dense vector
//   in_sub_chunk_start_i      : vector is first of a sub-chunk
//   in_last_i                 : vector is last of the chunk
// master = loader side, slave = packer side.
interface ifm_chunk_packer_if;
  import ifm_pack_pkg::*;

  logic in_valid_i;
  logic in_ready_o;
  vec_t in_data_i;
  logic in_sub_chunk_start_i;
  logic in_last_i;

  modport master (
    output in_valid_i,
    output in_data_i,
    output in_sub_chunk_start_i,
    output in_last_i,
    input  in_ready_o
  );

  modport slave (
    input  in_valid_i,
    input  in_data_i,
    input  in_sub_chunk_start_i,
    input  in_last_i,
    output in_ready_o
  );

endinterface

// File: rtl/ifm_pri_enc.sv
// Combinational lowest-set-bit encoder.
//   req : request vector
//   idx : index of the lowest set bit of req (0 when req is empty)
//   any : req has at least one bit set
module ifm_pri_enc #(
  parameter  int unsigned W  = 16,
  localparam int unsigned IW = $clog2(W)
) (
  input  logic [W-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top so the lowest set bit is the final assignment.
  always_comb begin
    idx = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
    any = |req;
  end

endmodule

// File: rtl/ifm_chunk_packer.sv
// Packs dense IFM vectors into a sparsemap word plus contiguously stored
// nonzero elements, in the order the read side's prefix-sum addressing uses.
//   clk_i, rst_ni      : clock, async active-low reset
//   in_if (slave)      : dense vector stream from the loader
//   spm_we_o/addr/data : sparsemap SRAM write port
//   dat_we_o/addr/data : data chunk SRAM write port
//   chunk_done_o       : one-cycle pulse when a chunk is complete
//   chunk_nz_cnt_o     : nonzero total of the chunk, valid with chunk_done_o
module ifm_chunk_packer
  import ifm_pack_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  ifm_chunk_packer_if.slave in_if,
  output logic              spm_we_o,
  output logic [SPM_AW-1:0] spm_addr_o,
  output mask_t             spm_data_o,
  output logic              dat_we_o,
  output logic [ADDR_W-1:0] dat_addr_o,
  output lane_t             dat_data_o,
  output logic              chunk_done_o,
  output logic [ADDR_W-1:0] chunk_nz_cnt_o
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [SPM_AW-1:0] spm_ptr_q, spm_ptr_d;
  mask_t             mask_q, mask_d;    // lanes still to be emitted
  vec_t              vec_q, vec_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  k_q, k_d;          // nonzeros emitted from current vector

  logic              ready_q, ready_d;
  logic              spm_we_q, spm_we_d;
  logic [SPM_AW-1:0] spm_addr_q, spm_addr_d;
  mask_t             spm_data_q, spm_data_d;
  logic              dat_we_q, dat_we_d;
  logic [ADDR_W-1:0] dat_addr_q, dat_addr_d;
  lane_t             dat_data_q, dat_data_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  mask_t             in_mask, enc_in;
  logic [LANE_W-1:0] enc_idx;
  logic              enc_any;
  logic              accept;
  logic [ADDR_W-1:0] eff_base;
  logic [SPM_AW-1:0] eff_spm;

  assign accept   = in_if.in_valid_i & ready_q;
  assign in_mask  = nz_mask(in_if.in_data_i);
  assign eff_base = in_if.in_sub_chunk_start_i ? '0 : base_q;
  assign eff_spm  = in_if.in_sub_chunk_start_i ? '0 : spm_ptr_q;

  // The first nonzero is picked straight from the incoming vector so its
  // write lands in the same cycle as the sparsemap write.
  assign enc_in = (state_q == IDLE) ? in_mask : mask_q;

  ifm_pri_enc #(.W(VEC_SIZE)) u_pri_enc (
    .req (enc_in),
    .idx (enc_idx),
    .any (enc_any)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state. An all-zero vector still spends one EMIT cycle (sparsemap
  // write only) so every vector takes max(n,1)+1 cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EMIT;
      EMIT:    if (mask_q == '0) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and next values of the registered outputs.
  always_comb begin
    base_d     = base_q;
    spm_ptr_d  = spm_ptr_q;
    mask_d     = mask_q;
    vec_d      = vec_q;
    last_d     = last_q;
    k_d        = k_q;
    ready_d    = (state_d == IDLE);
    spm_we_d   = 1'b0;
    spm_addr_d = spm_addr_q;
    spm_data_d = spm_data_q;
    dat_we_d   = 1'b0;
    dat_addr_d = dat_addr_q;
    dat_data_d = dat_data_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          base_d     = eff_base;
          spm_ptr_d  = eff_spm;
          vec_d      = in_if.in_data_i;
          last_d     = in_if.in_last_i | (eff_spm == SPM_AW'(SPM_DEPTH - 1));
          spm_we_d   = 1'b1;
          spm_addr_d = eff_spm;
          spm_data_d = in_mask;
          dat_we_d   = enc_any;
          dat_addr_d = eff_base;
          dat_data_d = in_if.in_data_i[enc_idx];
          mask_d     = in_mask & (in_mask - mask_t'(1));  // drop lowest set bit
          k_d        = CNT_W'(enc_any);
        end
      end
      EMIT: begin
        if (enc_any) begin
          dat_we_d   = 1'b1;
          dat_addr_d = base_q + ADDR_W'(k_q);
          dat_data_d = vec_q[enc_idx];
          mask_d     = mask_q & (mask_q - mask_t'(1));
          k_d        = k_q + CNT_W'(1);
        end else if (last_q) begin
          done_d = 1'b1;
          cnt_d  = base_q + ADDR_W'(k_q);
        end
      end
      FIN: begin
        if (last_q) begin
          base_d    = '0;
          spm_ptr_d = '0;
        end else begin
          base_d    = base_q + ADDR_W'(k_q);
          spm_ptr_d = spm_ptr_q + SPM_AW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q     <= '0;
      spm_ptr_q  <= '0;
      mask_q     <= '0;
      vec_q      <= '0;
      last_q     <= 1'b0;
      k_q        <= '0;
      ready_q    <= 1'b1;
      spm_we_q   <= 1'b0;
      spm_addr_q <= '0;
      spm_data_q <= '0;
      dat_we_q   <= 1'b0;
      dat_addr_q <= '0;
      dat_data_q <= '0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      base_q     <= base_d;
      spm_ptr_q  <= spm_ptr_d;
      mask_q     <= mask_d;
      vec_q      <= vec_d;
      last_q     <= last_d;
      k_q        <= k_d;
      ready_q    <= ready_d;
      spm_we_q   <= spm_we_d;
      spm_addr_q <= spm_addr_d;
      spm_data_q <= spm_data_d;
      dat_we_q   <= dat_we_d;
      dat_addr_q <= dat_addr_d;
      dat_data_q <= dat_data_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_if.in_ready_o = ready_q;
  assign spm_we_o         = spm_we_q;
  assign spm_addr_o       = spm_addr_q;
  assign spm_data_o       = spm_data_q;
  assign dat_we_o         = dat_we_q;
  assign dat_addr_o       = dat_addr_q;
  assign dat_data_o       = dat_data_q;
  assign chunk_done_o     = done_q;
  assign chunk_nz_cnt_o   = cnt_q;

endmodule

// File: tb/tb_ifm_chunk_packer.sv
// Self-checking bench for ifm_chunk_packer: directed scenarios plus random
// vectors, checked cycle by cycle against a queue-based reference model.
module tb_ifm_chunk_packer;
  import ifm_pack_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  ifm_chunk_packer_if in_if();

  logic              spm_we_o;
  logic [SPM_AW-1:0] spm_addr_o;
  mask_t             spm_data_o;
  logic              dat_we_o;
  logic [ADDR_W-1:0] dat_addr_o;
  lane_t             dat_data_o;
  logic              chunk_done_o;
  logic [ADDR_W-1:0] chunk_nz_cnt_o;

  ifm_chunk_packer dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .in_if          (in_if),
    .spm_we_o       (spm_we_o),
    .spm_addr_o     (spm_addr_o),
    .spm_data_o     (spm_data_o),
    .dat_we_o       (dat_we_o),
    .dat_addr_o     (dat_addr_o),
    .dat_data_o     (dat_data_o),
    .chunk_done_o   (chunk_done_o),
    .chunk_nz_cnt_o (chunk_nz_cnt_o)
  );

  typedef struct {
    int cyc;
    int addr;
    int data;
  } ev_t;

  ev_t spm_q[$];
  ev_t dat_q[$];
  ev_t done_q[$];

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int m_base = 0;        // model: next free data address in the chunk
  int m_idx = 0;         // model: next sparsemap word
  int acc_c = -10;       // cycle in which the last accept happened
  int busy_end = 0;      // first cycle in_ready_o is high again

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: derives every write of a vector from the packing rules.
  task automatic model_accept(input vec_t v, input bit sub, input bit last, input int c);
    ev_t e;
    int n = 0;
    int busy;
    logic [31:0] m = '0;
    if (sub) begin
      m_base = 0;
      m_idx  = 0;
    end
    for (int i = 0; i < int'(VEC_SIZE); i++) begin
      if (v[i] != 0) begin
        m[i]   = 1'b1;
        e.cyc  = c + 1 + n;
        e.addr = m_base + n;
        e.data = int'(v[i]);
        dat_q.push_back(e);
        n++;
      end
    end
    e.cyc = c + 1; e.addr = m_idx; e.data = m;
    spm_q.push_back(e);
    busy = (n > 0) ? n : 1;
    if (last || m_idx == int'(SPM_DEPTH) - 1) begin
      e.cyc = c + 1 + busy; e.addr = 0; e.data = m_base + n;
      done_q.push_back(e);
      m_base = 0;
      m_idx  = 0;
    end else begin
      m_base += n;
      m_idx++;
    end
    acc_c    = c;
    busy_end = c + 2 + busy;
  endtask

  task automatic model_reset();
    spm_q.delete();
    dat_q.delete();
    done_q.delete();
    m_base   = 0;
    m_idx    = 0;
    acc_c    = -10;
    busy_end = 0;
  endtask

  // Present one vector; with hold=1 valid stays high after the accept.
  task automatic send_vec(input vec_t v, input bit sub, input bit last, input bit hold);
    int w = 0;
    @(negedge clk_i);
    while (!in_if.in_ready_o && w < 200) begin
      @(negedge clk_i);
      w++;
    end
    if (w >= 200) begin
      chk("ready_timeout", 32'(in_if.in_ready_o), 32'd1);
      return;
    end
    in_if.in_data_i            = v;
    in_if.in_sub_chunk_start_i = sub;
    in_if.in_last_i            = last;
    in_if.in_valid_i           = 1'b1;
    model_accept(v, sub, last, cyc);
    @(posedge clk_i);
    #1;
    if (!hold) in_if.in_valid_i = 1'b0;
  endtask

  // Cycle monitor: every strobe and in_ready_o against the model's schedule.
  always @(negedge clk_i) begin
    bit e_we;
    bit e_rdy;
    e_rdy = !(cyc > acc_c && cyc < busy_end);
    chk("in_ready", 32'(in_if.in_ready_o), 32'(e_rdy));

    e_we = spm_q.size() > 0 && spm_q[0].cyc == cyc;
    chk("spm_we", 32'(spm_we_o), 32'(e_we));
    if (e_we && spm_we_o) begin
      chk("spm_addr", 32'(spm_addr_o), spm_q[0].addr);
      chk("spm_data", 32'(spm_data_o), spm_q[0].data);
    end
    if (e_we) void'(spm_q.pop_front());

    e_we = dat_q.size() > 0 && dat_q[0].cyc == cyc;
    chk("dat_we", 32'(dat_we_o), 32'(e_we));
    if (e_we && dat_we_o) begin
      chk("dat_addr", 32'(dat_addr_o), dat_q[0].addr);
      chk("dat_data", 32'(dat_data_o), dat_q[0].data);
    end
    if (e_we) void'(dat_q.pop_front());

    e_we = done_q.size() > 0 && done_q[0].cyc == cyc;
    chk("chunk_done", 32'(chunk_done_o), 32'(e_we));
    if (e_we && chunk_done_o) chk("chunk_nz_cnt", 32'(chunk_nz_cnt_o), done_q[0].data);
    if (e_we) void'(done_q.pop_front());
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int dens;
    bit hold;
    in_if.in_valid_i            = 1'b0;
    in_if.in_data_i             = '0;
    in_if.in_sub_chunk_start_i  = 1'b0;
    in_if.in_last_i             = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    // Three sparse lanes, single-vector chunk.
    v = '0; v[0] = 8'd5; v[3] = 8'd7; v[15] = 8'd9;
    send_vec(v, 1'b1, 1'b1, 1'b0);

    // All-zero vector, then one nonzero.
    v = '0;
    send_vec(v, 1'b1, 1'b0, 1'b0);
    v[2] = 8'd4;
    send_vec(v, 1'b0, 1'b1, 1'b0);

    // Eight dense vectors: 8th forced last; next vector restarts at 0/0.
    for (int i = 0; i < int'(SPM_DEPTH); i++) begin
      for (int j = 0; j < int'(VEC_SIZE); j++) v[j] = 8'd1;
      send_vec(v, (i == 0), 1'b0, 1'b0);
    end
    v = '0; v[7] = 8'd33;
    send_vec(v, 1'b0, 1'b1, 1'b0);

    // Two-vector chunk (3 then 2 nonzeros), then a new sub-chunk.
    v = '0; v[1] = 8'd11; v[4] = 8'd12; v[9] = 8'd13;
    send_vec(v, 1'b1, 1'b0, 1'b0);
    v = '0; v[0] = 8'd21; v[14] = 8'd22;
    send_vec(v, 1'b0, 1'b1, 1'b0);
    v = '0; v[5] = 8'd31; v[6] = 8'd32;
    send_vec(v, 1'b1, 1'b0, 1'b0);

    // Valid held high through EMIT/FIN.
    v = '0; v[2] = 8'd41; v[3] = 8'd42; v[12] = 8'd43;
    send_vec(v, 1'b0, 1'b0, 1'b1);
    v = '0; v[8] = 8'd51;
    send_vec(v, 1'b0, 1'b1, 1'b0);

    // Reset during the 3rd EMIT cycle of a 10-nonzero vector.
    v = '0;
    for (int j = 0; j < 10; j++) v[j] = 8'(60 + j);
    send_vec(v, 1'b1, 1'b0, 1'b0);
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("rst_async_dat_we", 32'(dat_we_o), 32'd0);
    chk("rst_async_spm_we", 32'(spm_we_o), 32'd0);
    chk("rst_async_done", 32'(chunk_done_o), 32'd0);
    repeat (2) @(negedge clk_i);
    #1;
    rst_ni = 1'b1;
    v = '0; v[10] = 8'd77; v[11] = 8'd78;
    send_vec(v, 1'b0, 1'b1, 1'b0);

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      dens = $urandom_range(0, 4);
      for (int j = 0; j < int'(VEC_SIZE); j++) begin
        if ($urandom_range(0, 3) < dens) v[j] = 8'($urandom_range(1, 255));
        else                             v[j] = 8'd0;
      end
      hold = (t != 59) && ($urandom_range(0, 3) == 0);
      send_vec(v, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    repeat (40) @(negedge clk_i);
    chk("spm_q_drained", 32'(spm_q.size()), 32'd0);
    chk("dat_q_drained", 32'(dat_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
